// File: rtl/uart_rx_top.sv
// UART receiver. Oversamples the serial line, recovers frames of
// start(0), DATAWIDTH data bits LSB-first, an optional parity bit and stop(1),
// and reports each frame with a one-cycle strobe.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   RX_IN      asynchronous serial line, idles high
//   PAR_EN     1 = frame carries a parity bit (latched at start detection)
//   PAR_TYP    0 = even, 1 = odd parity (latched at start detection)
//   P_DATA     last good data word
//   DATA_VALID one-cycle strobe, P_DATA holds a good frame
//   PAR_ERR    one-cycle strobe, parity mismatch
//   STP_ERR    one-cycle strobe, stop bit sampled 0
//   RX_BUSY    high whenever the receiver is not idle
module uart_rx_top #(
  parameter int unsigned DATAWIDTH  = 8,
  parameter int unsigned OVERSAMPLE = 8,
  parameter int unsigned CNTWIDTH   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX_IN,
  input  logic                 PAR_EN,
  input  logic                 PAR_TYP,
  output logic [DATAWIDTH-1:0] P_DATA,
  output logic                 DATA_VALID,
  output logic                 PAR_ERR,
  output logic                 STP_ERR,
  output logic                 RX_BUSY
);

  localparam logic [CNTWIDTH-1:0] EdgeLast  = CNTWIDTH'(OVERSAMPLE - 1);
  localparam logic [CNTWIDTH-1:0] SampFirst = CNTWIDTH'(OVERSAMPLE / 2 - 1);
  localparam logic [CNTWIDTH-1:0] SampMid   = CNTWIDTH'(OVERSAMPLE / 2);
  localparam logic [CNTWIDTH-1:0] SampLast  = CNTWIDTH'(OVERSAMPLE / 2 + 1);
  localparam logic [CNTWIDTH-1:0] BitLast   = CNTWIDTH'(DATAWIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e state_q, state_d;

  logic                 sync1_q, rx_s_q;
  logic [CNTWIDTH-1:0]  edge_cnt_q, edge_cnt_d;
  logic [CNTWIDTH-1:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATAWIDTH-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d;
  logic                 par_typ_q, par_typ_d;
  logic                 par_bad_q, par_bad_d;
  logic                 stop_bit_q, stop_bit_d;
  logic [DATAWIDTH-1:0] p_data_q, p_data_d;
  logic                 dv_q, dv_d;
  logic                 pe_q, pe_d;
  logic                 se_q, se_d;

  logic edge_wrap;
  logic decide;
  logic maj_bit;

  assign edge_wrap = (edge_cnt_q == EdgeLast);
  assign decide    = (edge_cnt_q == SampLast);
  // Third sample is the live rx_s at the decision slot.
  assign maj_bit   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= StIdle;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      samp_q     <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bad_q  <= 1'b0;
      stop_bit_q <= 1'b1;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      sync1_q    <= RX_IN;
      rx_s_q     <= sync1_q;
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_bad_q  <= par_bad_d;
      stop_bit_q <= stop_bit_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_bad_d  = par_bad_q;
    stop_bit_d = stop_bit_q;
    p_data_d   = p_data_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;

    if (state_q != StIdle) begin
      edge_cnt_d = edge_wrap ? '0 : edge_cnt_q + CNTWIDTH'(1);
      if (edge_cnt_q == SampFirst) samp_d[0] = rx_s_q;
      if (edge_cnt_q == SampMid)   samp_d[1] = rx_s_q;
    end

    unique case (state_q)
      StIdle: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx_s_q) begin
          // Detect cycle is slot 0 of the start bit.
          state_d    = StStart;
          edge_cnt_d = CNTWIDTH'(1);
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_bad_d  = 1'b0;
        end
      end
      StStart: begin
        if (decide && maj_bit) begin
          // Line was back high at mid-bit: treat as a glitch.
          state_d    = StIdle;
          edge_cnt_d = '0;
        end else if (edge_wrap) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        // Right shift: after DATAWIDTH bits the first one sits at bit 0.
        if (decide) shift_d = {maj_bit, shift_q[DATAWIDTH-1:1]};
        if (edge_wrap) begin
          if (bit_cnt_q == BitLast) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + CNTWIDTH'(1);
          end
        end
      end
      StParity: begin
        if (decide) par_bad_d = maj_bit ^ (^shift_q) ^ par_typ_q;
        if (edge_wrap) state_d = StStop;
      end
      StStop: begin
        if (decide) stop_bit_d = maj_bit;
        if (edge_wrap) begin
          state_d = StIdle;
          pe_d    = par_en_q & par_bad_q;
          se_d    = ~stop_bit_q;
          dv_d    = ~(par_en_q & par_bad_q) & stop_bit_q;
          if (~(par_en_q & par_bad_q) & stop_bit_q) p_data_d = shift_q;
        end
      end
      default: begin
        state_d    = StIdle;
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = dv_q;
  assign PAR_ERR    = pe_q;
  assign STP_ERR    = se_q;
  assign RX_BUSY    = (state_q != StIdle);

endmodule

// File: doc/uart_rx_top.md
Name: uart_rx_top

Overview:
- UART receiver, the far end of the existing UART transmit path.
- Oversamples serial RX_IN with an internal bit-rate counter and recovers frames of start(0), DATAWIDTH data bits LSB-first, an optional parity bit and stop(1).
- Presents each frame on P_DATA with a one-cycle DATA_VALID strobe.
- Flags parity and stop errors, and feeds the system-side consumer of received bytes.

Parameters:
- DATAWIDTH, 8, data bits per frame.
- OVERSAMPLE, 8, clock cycles per bit. Legal values are even numbers ≥ 6.
- CNTWIDTH, 5, width of the edge and bit counters. Must hold both OVERSAMPLE-1 and DATAWIDTH.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- RX_IN  input  1  asynchronous serial line; idles high.
- PAR_EN  input  1  1 = the frame carries a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- P_DATA  output  DATAWIDTH  last received data word.
- DATA_VALID  output  1  one-cycle strobe; P_DATA holds a good frame.
- PAR_ERR  output  1  one-cycle strobe; parity mismatch.
- STP_ERR  output  1  one-cycle strobe; stop bit sampled 0.
- RX_BUSY  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - Synchronizer flops reset to 1 and the FSM goes to IDLE.
  - P_DATA = 0; DATA_VALID, PAR_ERR, STP_ERR and RX_BUSY = 0.
  - All counters reset to 0.
  - Reset asserted mid-frame aborts the frame with no strobe; the next cycle is IDLE.
- Input synchronizer: RX_IN passes through 2 flops. The FSM sees rx_s, which lags RX_IN by 2 cycles.
- Bit timing:
  - edge_cnt runs 0..OVERSAMPLE-1 within each bit and wraps to 0.
  - On the wrap, bit_cnt increments (DATA state) or the state advances.
- Sampling:
  - rx_s is captured at edge_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit value is the majority of the 3 samples, decided at edge_cnt = OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when rx_s = 0, go to START with edge_cnt = 1, so the detect cycle counts as sample slot 0. In the same cycle latch PAR_EN and PAR_TYP. Mid-frame changes on those pins are ignored.
  - START: if the majority bit = 1 (glitch), return to IDLE at the decision cycle with no strobes. Otherwise go to DATA at the wrap.
  - DATA: shift the majority bit into the shift register at position bit_cnt (LSB first). After bit DATAWIDTH-1 wraps, go to PARITY if the latched PAR_EN = 1, else to STOP.
  - PARITY: expected bit = XOR of the data bits XOR latched PAR_TYP. Record a mismatch flag at the decision cycle; go to STOP at the wrap.
  - STOP: record the sampled stop bit. At the wrap (edge_cnt = OVERSAMPLE-1) go to IDLE.
- Outputs, registered in the cycle after the STOP wrap cycle:
  - No error: P_DATA <= shift register and DATA_VALID = 1 for 1 cycle.
  - Parity error: PAR_ERR = 1 and DATA_VALID = 0.
  - Stop error: STP_ERR = 1 and DATA_VALID = 0.
  - Both errors may assert together.
  - P_DATA is updated only on a valid frame and otherwise holds its value.
- Latency: with F = 10 + PAR_EN frame bits, a RX_IN falling edge at cycle 0 gives DATA_VALID at cycle 2 + F*OVERSAMPLE.
- Back-to-back frames:
  - IDLE is re-entered the cycle after the STOP wrap and detects a start bit that begins immediately.
  - The strobe cycle and the new start detection may coincide.
- rx_s held low through a stop bit (break) → STP_ERR. Afterwards IDLE immediately sees 0 and starts a new frame; this is accepted behaviour.
- RX_BUSY = 1 from the cycle after start detection until IDLE is re-entered.

Test Plan:
1. OVERSAMPLE=8, PAR_EN=0; send 0xA5 (line: 0, 1,0,1,0,0,1,0,1, 1) → DATA_VALID for 1 cycle at cycle 82 after the start edge, P_DATA=0xA5, no error strobes.
2. PAR_EN=1, PAR_TYP=0; send 0xA5 with parity 0 → P_DATA=0xA5, DATA_VALID at cycle 90. Repeat with parity bit 1 → PAR_ERR pulse, DATA_VALID=0, P_DATA stays 0xA5.
3. PAR_EN=1, PAR_TYP=1; send 0x07 with parity 0 (odd) → DATA_VALID, P_DATA=0x07. Send 0x3C with stop bit 0 → STP_ERR pulse only.
4. 2-cycle low glitch on RX_IN while idle → returns to IDLE, RX_BUSY drops by the decision cycle, no strobes. A following real frame 0x5A is received correctly.
5. Frames 0x11, 0x22, 0x33 back-to-back with no idle gap → three DATA_VALID strobes exactly 80 cycles apart with matching P_DATA. Add a single-cycle low spike at a sample point mid-bit → majority vote keeps the data correct.
6. Assert rst for 1 cycle in the middle of data bit 4 → outputs reset to 0 and no strobe. The next full frame 0xC3 is received correctly.
